// File: rtl/unidade_hazard.sv
// rtl/unidade_hazard.sv - MIPS five-stage hazard unit: forwarding selects, load-use bubble, mult/div freeze
module unidade_hazard #(
  parameter logic [3:0] LAT_MULT = 4'd4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       id_valido,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_usa_rs,
  input  logic       id_usa_rt,
  input  logic [4:0] id_rd,
  input  logic       id_escreve,
  input  logic       id_le_mem,
  input  logic       id_multiciclo,
  output logic       controle1P,
  output logic       controle2P,
  output logic       controle1S,
  output logic       controle2S,
  output logic       pc_escreve,
  output logic       ifid_escreve,
  output logic       idex_bolha,
  output logic       ex_segura,
  output logic       ocupado
);

  typedef enum logic {OCIOSO, MULTI} estado_t;

  estado_t    estado, prox_estado;
  logic [3:0] cnt, prox_cnt;

  logic       ex_valido, ex_escreve, ex_le_mem;
  logic [4:0] ex_rd;
  logic       mem_valido, mem_escreve;
  logic [4:0] mem_rd;

  logic [1:0] sel_rs, sel_rt;
  logic       lu, avanca;

  // EX/MEM (newer producer) beats MEM/WB; $0 never forwards
  function automatic logic [1:0] seleciona(input logic [4:0] fonte, input logic usa);
    logic [1:0] r;
    r = 2'b00;
    if (usa && fonte != 5'd0) begin
      if (ex_valido && ex_escreve && ex_rd == fonte)
        r = 2'b01;
      else if (mem_valido && mem_escreve && mem_rd == fonte)
        r = 2'b10;
    end
    return r;
  endfunction

  assign lu = id_valido && ex_valido && ex_le_mem && ex_escreve && ex_rd != 5'd0 &&
              ((id_usa_rs && id_rs == ex_rd) || (id_usa_rt && id_rt == ex_rd));

  always_comb begin
    prox_estado  = estado;
    prox_cnt     = cnt;
    avanca       = (estado == OCIOSO) && !lu;
    pc_escreve   = 1'b1;
    ifid_escreve = 1'b1;
    idex_bolha   = 1'b0;
    ex_segura    = 1'b0;
    ocupado      = 1'b0;
    case (estado)
      OCIOSO: begin
        if (lu) begin
          pc_escreve   = 1'b0;
          ifid_escreve = 1'b0;
          idex_bolha   = 1'b1;
        end
        if (avanca && id_valido && id_multiciclo) begin
          prox_estado = MULTI;
          prox_cnt    = LAT_MULT - 4'd1;
        end
      end
      MULTI: begin
        pc_escreve   = 1'b0;
        ifid_escreve = 1'b0;
        ex_segura    = 1'b1;
        ocupado      = 1'b1;
        prox_cnt     = cnt - 4'd1;
        if (cnt == 4'd1)
          prox_estado = OCIOSO;
      end
      default: prox_estado = OCIOSO;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      estado      <= OCIOSO;
      cnt         <= 4'd0;
      ex_valido   <= 1'b0;
      ex_escreve  <= 1'b0;
      ex_le_mem   <= 1'b0;
      ex_rd       <= 5'd0;
      mem_valido  <= 1'b0;
      mem_escreve <= 1'b0;
      mem_rd      <= 5'd0;
      sel_rs      <= 2'b00;
      sel_rt      <= 2'b00;
    end else begin
      estado <= prox_estado;
      cnt    <= prox_cnt;
      if (estado == MULTI) begin
        // EX and the selects hold; MEM receives bubbles while mult/div works
        mem_valido  <= 1'b0;
        mem_escreve <= 1'b0;
        mem_rd      <= 5'd0;
      end else begin
        mem_valido  <= ex_valido;
        mem_escreve <= ex_escreve;
        mem_rd      <= ex_rd;
        if (lu) begin
          ex_valido  <= 1'b0;
          ex_escreve <= 1'b0;
          ex_le_mem  <= 1'b0;
          ex_rd      <= 5'd0;
          sel_rs     <= 2'b00;
          sel_rt     <= 2'b00;
        end else begin
          ex_valido  <= id_valido;
          ex_escreve <= id_valido && id_escreve;
          ex_le_mem  <= id_valido && id_le_mem;
          ex_rd      <= id_valido ? id_rd : 5'd0;
          sel_rs     <= seleciona(id_rs, id_valido && id_usa_rs);
          sel_rt     <= seleciona(id_rt, id_valido && id_usa_rt);
        end
      end
    end
  end

  assign controle1P = sel_rs[1];
  assign controle2P = sel_rs[0];
  assign controle1S = sel_rt[1];
  assign controle2S = sel_rt[0];

endmodule

// File: tb/tb_unidade_hazard.sv
// tb/tb_unidade_hazard.sv - randomized bench for unidade_hazard against a stage-list reference model
module tb_unidade_hazard;

  localparam logic [3:0] LAT = 4'd4;

  logic       clock = 1'b0;
  logic       reset;
  logic       id_valido, id_usa_rs, id_usa_rt, id_escreve, id_le_mem, id_multiciclo;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       controle1P, controle2P, controle1S, controle2S;
  logic       pc_escreve, ifid_escreve, idex_bolha, ex_segura, ocupado;

  always #5 clock = ~clock;

  unidade_hazard #(.LAT_MULT(LAT)) dut (
    .clock(clock), .reset(reset),
    .id_valido(id_valido), .id_rs(id_rs), .id_rt(id_rt),
    .id_usa_rs(id_usa_rs), .id_usa_rt(id_usa_rt), .id_rd(id_rd),
    .id_escreve(id_escreve), .id_le_mem(id_le_mem), .id_multiciclo(id_multiciclo),
    .controle1P(controle1P), .controle2P(controle2P),
    .controle1S(controle1S), .controle2S(controle2S),
    .pc_escreve(pc_escreve), .ifid_escreve(ifid_escreve), .idex_bolha(idex_bolha),
    .ex_segura(ex_segura), .ocupado(ocupado)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic verifica(input string tag, input logic [3:0] obs, input logic [3:0] esp);
    n_total++;
    if (obs === esp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, esp, $time);
  endtask

  typedef struct {
    bit       v;
    bit [4:0] rd;
    bit       wr;
    bit       ld;
  } instr_t;

  instr_t   m_ex, m_mem;
  int       m_busy;
  bit [1:0] m_sel_rs, m_sel_rt;

  function automatic bit [1:0] m_fwd(input bit [4:0] src, input bit usa);
    instr_t prod[2];
    prod[0] = m_ex;
    prod[1] = m_mem;
    if (!usa || src == 5'd0) return 2'b00;
    for (int i = 0; i < 2; i++)
      if (prod[i].v && prod[i].wr && prod[i].rd == src) return 2'(i + 1);
    return 2'b00;
  endfunction

  function automatic bit m_lu();
    if (!(id_valido && m_ex.v && m_ex.ld && m_ex.wr && m_ex.rd != 5'd0)) return 1'b0;
    return (id_usa_rs && id_rs == m_ex.rd) || (id_usa_rt && id_rt == m_ex.rd);
  endfunction

  task automatic model_edge();
    instr_t bolha, novo;
    bit     lu;
    bolha = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
    lu = m_lu();
    if (reset) begin
      m_ex = bolha; m_mem = bolha; m_busy = 0; m_sel_rs = 2'b00; m_sel_rt = 2'b00;
    end else if (m_busy > 0) begin
      m_busy--;
      m_mem = bolha;
    end else if (lu) begin
      m_mem = m_ex; m_ex = bolha; m_sel_rs = 2'b00; m_sel_rt = 2'b00;
    end else begin
      m_sel_rs = m_fwd(id_rs, id_valido && id_usa_rs);
      m_sel_rt = m_fwd(id_rt, id_valido && id_usa_rt);
      novo = id_valido ? '{v: 1'b1, rd: id_rd, wr: id_escreve, ld: id_le_mem} : bolha;
      m_mem = m_ex;
      m_ex  = novo;
      if (id_valido && id_multiciclo) m_busy = int'(LAT) - 1;
    end
  endtask

  task automatic confere();
    bit multi, lu;
    multi = m_busy > 0;
    lu    = m_lu();
    verifica("sel_rs",  {2'b00, controle1P, controle2P}, {2'b00, m_sel_rs});
    verifica("sel_rt",  {2'b00, controle1S, controle2S}, {2'b00, m_sel_rt});
    verifica("pc_escreve",   {3'b000, pc_escreve},   {3'b000, !(multi || lu)});
    verifica("ifid_escreve", {3'b000, ifid_escreve}, {3'b000, !(multi || lu)});
    verifica("idex_bolha",   {3'b000, idex_bolha},   {3'b000, lu && !multi});
    verifica("ex_segura",    {3'b000, ex_segura},    {3'b000, multi});
    verifica("ocupado",      {3'b000, ocupado},      {3'b000, multi});
  endtask

  task automatic ciclo();
    #1 confere();
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic ocioso();
    id_valido = 0; id_rs = 0; id_rt = 0; id_rd = 0; id_usa_rs = 0; id_usa_rt = 0;
    id_escreve = 0; id_le_mem = 0; id_multiciclo = 0;
  endtask

  initial begin
    reset = 1'b1;
    ocioso();
    m_ex = '{v: 1'b0, rd: 5'd0, wr: 1'b0, ld: 1'b0};
    m_mem = m_ex; m_busy = 0; m_sel_rs = 2'b00; m_sel_rt = 2'b00;
    @(negedge clock);
    ciclo();
    reset = 1'b0;
    #1;
    verifica("rst_pc",      {3'b000, pc_escreve}, 4'd1);
    verifica("rst_bolha",   {3'b000, idex_bolha}, 4'd0);
    verifica("rst_ocupado", {3'b000, ocupado},    4'd0);
    verifica("rst_sel",     {controle1P, controle2P, controle1S, controle2S}, 4'd0);

    repeat (800) begin
      reset         = ($urandom_range(0, 39) == 0);
      id_valido     = ($urandom_range(0, 5) != 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_rd         = 5'($urandom_range(0, 3));
      id_usa_rs     = $urandom_range(0, 3) != 0;
      id_usa_rt     = $urandom_range(0, 1) != 0;
      id_escreve    = $urandom_range(0, 3) != 0;
      id_le_mem     = $urandom_range(0, 3) == 0;
      id_multiciclo = $urandom_range(0, 9) == 0;
      ciclo();
    end

    // mult enters EX, then reset lands in its second busy cycle
    reset = 1'b1; ocioso(); ciclo();
    reset = 1'b0; id_valido = 1; id_multiciclo = 1; id_escreve = 1; id_rd = 5'd3; ciclo();
    ocioso(); ciclo();
    reset = 1'b1; ciclo();
    reset = 1'b0; ciclo();
    verifica("abort_ocupado", {3'b000, ocupado}, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
